// File: rtl/lp_pkg.sv
// Shared types and constants for the multi-channel logic probe (LP_EDGE_COUNT_EN adds edge counting).
// Latency: none, this file only holds declarations and pure helper functions.
// Backpressure: not applicable.
package lp_pkg;

    // R2R DAC codes for the high-comparator threshold of each logic family
    localparam logic [3:0] DAC_CODE_1V8 = 4'd7;
    localparam logic [3:0] DAC_CODE_2V5 = 4'd10;
    localparam logic [3:0] DAC_CODE_3V3 = 4'd12;

    typedef enum logic [1:0] {
        MODE_1V8 = 2'd0,
        MODE_2V5 = 2'd1,
        MODE_3V3 = 2'd2,
        MODE_5V0 = 2'd3
    } mode_t;

    // Probe state seen through the comparator pair
    typedef enum logic [1:0] {
        PS_FLOAT    = 2'd0,
        PS_ONE      = 2'd1,
        PS_ZERO     = 2'd2,
        PS_CONFLICT = 2'd3
    } probe_state_t;

    function automatic logic [3:0] dac_code(input mode_t m);
        case (m)
            MODE_1V8: return DAC_CODE_1V8;
            MODE_2V5: return DAC_CODE_2V5;
            default:  return DAC_CODE_3V3;
        endcase
    endfunction

    function automatic probe_state_t probe_state(input logic hi, input logic lo);
        case ({hi, lo})
            2'b10:   return PS_ONE;
            2'b01:   return PS_ZERO;
            2'b11:   return PS_CONFLICT;
            default: return PS_FLOAT;
        endcase
    endfunction

endpackage

// File: rtl/lp_channel.sv
// One probe channel: synchronizer, per-state sample counters, brightness, PWM LEDs, pulse hold (LP_EDGE_COUNT_EN adds edge_count).
// Latency: comp -> sh/sl 2 cycles; brightness loads in the latch cycle, LEDs follow from the next cycle.
// Backpressure: none; free-running, outputs always valid.
module lp_channel #(
    parameter int WIN_W    = 20,
    parameter int BR_W     = 8,
    parameter int HOLD_WIN = 3
) (
    input  logic            clk,
    input  logic            pulse_reset,
    input  logic            comp_hi,
    input  logic            comp_lo,
    input  logic            latch,
    input  logic [BR_W-1:0] phase_nxt,
    output logic            led_one,
    output logic            led_zero,
    output logic            led_floating,
    output logic            led_pulse,
    output logic            conflict
`ifdef LP_EDGE_COUNT_EN
    ,
    output logic [15:0]     edge_count
`endif
);
    import lp_pkg::*;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_WIN);

    logic             hi_meta, lo_meta, sh, sl, sh_q;
    probe_state_t     st, st_q;
    logic             edge_now, is_conf;
    logic             inc_one, inc_zero, inc_float;
    logic [WIN_W-1:0] cnt_one, cnt_zero, cnt_float;
    logic [WIN_W-1:0] sum_one, sum_zero, sum_float;
    logic [BR_W-1:0]  br_one, br_zero, br_float;
    logic [BR_W-1:0]  br_one_nxt, br_zero_nxt, br_float_nxt;
    logic             conf_acc, edge_flag;
    logic [3:0]       hold_cnt, hold_nxt;

    // Two-flop synchronizers for the asynchronous comparator outputs
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            hi_meta <= 1'b0;
            sh      <= 1'b0;
            lo_meta <= 1'b0;
            sl      <= 1'b0;
        end else begin
            hi_meta <= comp_hi;
            sh      <= hi_meta;
            lo_meta <= comp_lo;
            sl      <= lo_meta;
        end
    end

    // Previous synchronized values for edge detection
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            sh_q <= 1'b0;
            st_q <= PS_FLOAT;
        end else begin
            sh_q <= sh;
            st_q <= st;
        end
    end

    // Classify the sample; saturating sums include this cycle so a latch captures it
    always_comb begin
        st        = probe_state(sh, sl);
        edge_now  = (sh ^ sh_q) | (st != st_q);
        is_conf   = (st == PS_CONFLICT);
        inc_one   = (st == PS_ONE)   && (cnt_one   != '1);
        inc_zero  = (st == PS_ZERO)  && (cnt_zero  != '1);
        inc_float = (st == PS_FLOAT) && (cnt_float != '1);
        sum_one   = cnt_one   + WIN_W'(inc_one);
        sum_zero  = cnt_zero  + WIN_W'(inc_zero);
        sum_float = cnt_float + WIN_W'(inc_float);
        br_one_nxt   = latch ? sum_one[WIN_W-1 -: BR_W]   : br_one;
        br_zero_nxt  = latch ? sum_zero[WIN_W-1 -: BR_W]  : br_zero;
        br_float_nxt = latch ? sum_float[WIN_W-1 -: BR_W] : br_float;
        hold_nxt = hold_cnt;
        if (latch) begin
            if (edge_flag | edge_now) begin
                hold_nxt = HOLD_LOAD;
            end else if (hold_cnt != 4'd0) begin
                hold_nxt = hold_cnt - 4'd1;
            end
        end
    end

    // Per-window sample counters, restarting after the latch cycle
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            cnt_one   <= '0;
            cnt_zero  <= '0;
            cnt_float <= '0;
        end else if (latch) begin
            cnt_one   <= '0;
            cnt_zero  <= '0;
            cnt_float <= '0;
        end else begin
            cnt_one   <= sum_one;
            cnt_zero  <= sum_zero;
            cnt_float <= sum_float;
        end
    end

    // Window results: brightness, pulse hold, conflict and edge accumulators
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            br_one    <= '0;
            br_zero   <= '0;
            br_float  <= '0;
            hold_cnt  <= 4'd0;
            conf_acc  <= 1'b0;
            conflict  <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            br_one    <= br_one_nxt;
            br_zero   <= br_zero_nxt;
            br_float  <= br_float_nxt;
            hold_cnt  <= hold_nxt;
            conf_acc  <= latch ? 1'b0 : (conf_acc | is_conf);
            conflict  <= latch ? (conf_acc | is_conf) : conflict;
            edge_flag <= latch ? 1'b0 : (edge_flag | edge_now);
        end
    end

    // LED drives use next-cycle phase/brightness so the registered output matches the current window state
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            led_one      <= 1'b0;
            led_zero     <= 1'b0;
            led_floating <= 1'b0;
            led_pulse    <= 1'b0;
        end else begin
            led_one      <= (phase_nxt < br_one_nxt);
            led_zero     <= (phase_nxt < br_zero_nxt);
            led_floating <= (phase_nxt < br_float_nxt);
            led_pulse    <= (hold_nxt != 4'd0);
        end
    end

`ifdef LP_EDGE_COUNT_EN
    logic        rise;
    logic [15:0] edge_acc, edge_sum;

    assign rise     = sh & ~sh_q;
    assign edge_sum = edge_acc + 16'(rise && (edge_acc != 16'hFFFF));

    // Saturating rising-edge count, published in the latch cycle
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            edge_acc   <= 16'd0;
            edge_count <= 16'd0;
        end else begin
            edge_acc   <= latch ? 16'd0 : edge_sum;
            edge_count <= latch ? edge_sum : edge_count;
        end
    end
`endif

endmodule

// File: rtl/logic_probe_multi.sv
// Multi-channel logic probe: shared window counter, per-channel state LEDs, DAC threshold select (LP_EDGE_COUNT_EN adds edge_count).
// Latency: 2-cycle input sync; results latch once per 2^WIN_W-cycle window; dac_value follows mode after one clk.
// Backpressure: none; outputs are free-running status drives.
module logic_probe_multi #(
    parameter int NUM_CH   = 4,
    parameter int WIN_W    = 20,
    parameter int BR_W     = 8,
    parameter int HOLD_WIN = 3
) (
    input  logic              clk,
    input  logic              pulse_reset,
    input  logic [NUM_CH-1:0] comp_hi,
    input  logic [NUM_CH-1:0] comp_lo,
    input  logic [1:0]        mode,
    output logic [3:0]        dac_value,
    output logic [NUM_CH-1:0] led_one,
    output logic [NUM_CH-1:0] led_zero,
    output logic [NUM_CH-1:0] led_floating,
    output logic [NUM_CH-1:0] led_pulse,
    output logic [NUM_CH-1:0] conflict,
    output logic              win_tick
`ifdef LP_EDGE_COUNT_EN
    ,
    output logic [NUM_CH*16-1:0] edge_count
`endif
);
    import lp_pkg::*;

    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic             latch;

    assign win_cnt_nxt = win_cnt + WIN_W'(1);
    assign latch       = (win_cnt == '1);
    assign win_tick    = latch;

    // Free-running window counter; wraps to 0 after the latch cycle
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt_nxt;
        end
    end

    // Threshold code follows mode one clock later, independent of window state
    always_ff @(posedge clk or negedge pulse_reset) begin
        if (!pulse_reset) begin
            dac_value <= DAC_CODE_3V3;
        end else begin
            dac_value <= dac_code(mode_t'(mode));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lp_channel #(
            .WIN_W    (WIN_W),
            .BR_W     (BR_W),
            .HOLD_WIN (HOLD_WIN)
        ) u_ch (
            .clk          (clk),
            .pulse_reset  (pulse_reset),
            .comp_hi      (comp_hi[i]),
            .comp_lo      (comp_lo[i]),
            .latch        (latch),
            .phase_nxt    (win_cnt_nxt[BR_W-1:0]),
            .led_one      (led_one[i]),
            .led_zero     (led_zero[i]),
            .led_floating (led_floating[i]),
            .led_pulse    (led_pulse[i]),
            .conflict     (conflict[i])
`ifdef LP_EDGE_COUNT_EN
            ,
            .edge_count   (edge_count[i*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_logic_probe_multi.sv
// Bench for logic_probe_multi with 1024-cycle windows; window-level reference model plus directed scenarios.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: not applicable.
module tb_logic_probe_multi;
    localparam int NUM_CH = 4;
    localparam int WIN_W  = 10;
    localparam int BR_W   = 8;
    localparam int HOLD   = 3;
    localparam int WIN    = 1 << WIN_W;
    localparam int PH     = 1 << BR_W;

    logic              clk = 1'b0;
    logic              pulse_reset;
    logic [NUM_CH-1:0] comp_hi, comp_lo;
    logic [1:0]        mode;
    logic [3:0]        dac_value;
    logic [NUM_CH-1:0] led_one, led_zero, led_floating, led_pulse, conflict;
    logic              win_tick;
`ifdef LP_EDGE_COUNT_EN
    logic [NUM_CH*16-1:0] edge_count;
`endif

    always #5 clk = ~clk;

    logic_probe_multi #(
        .NUM_CH(NUM_CH), .WIN_W(WIN_W), .BR_W(BR_W), .HOLD_WIN(HOLD)
    ) dut (
        .clk          (clk),
        .pulse_reset  (pulse_reset),
        .comp_hi      (comp_hi),
        .comp_lo      (comp_lo),
        .mode         (mode),
        .dac_value    (dac_value),
        .led_one      (led_one),
        .led_zero     (led_zero),
        .led_floating (led_floating),
        .led_pulse    (led_pulse),
        .conflict     (conflict),
        .win_tick     (win_tick)
`ifdef LP_EDGE_COUNT_EN
        ,
        .edge_count   (edge_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: window position, 2-sample delay line, per-window tallies
    int         m_w;
    logic [3:0] q_hi[$], q_lo[$];
    logic [3:0] p_hi, p_lo;
    int         n_one[NUM_CH], n_zero[NUM_CH], n_flt[NUM_CH];
    int         b_one[NUM_CH], b_zero[NUM_CH], b_flt[NUM_CH];
    int         hold[NUM_CH], rises[NUM_CH], ecnt[NUM_CH];
    bit         acc[NUM_CH], conf[NUM_CH], eflag[NUM_CH];
    int         m_dac;

    logic [3:0] drv_hi, drv_lo;
    logic [1:0] drv_mode;

    int mis_pwm, mis_pulse, mis_conf, mis_tick, mis_dac, mis_ecnt;
    int c_one[NUM_CH], c_zero[NUM_CH], c_flt[NUM_CH], c_pulse[NUM_CH];
    bit obs_tick;

    function automatic int dac_of(input int md);
        if (md == 0) return 7;
        if (md == 1) return 10;
        return 12;
    endfunction

    function automatic int bright_of(input int n);
        int s;
        s = (n > WIN - 1) ? WIN - 1 : n;
        return s / (WIN / PH);
    endfunction

    task automatic model_reset();
        m_w = 0;
        q_hi.delete(); q_lo.delete();
        q_hi.push_back(4'd0); q_hi.push_back(4'd0);
        q_lo.push_back(4'd0); q_lo.push_back(4'd0);
        p_hi = 4'd0; p_lo = 4'd0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            n_one[ch] = 0; n_zero[ch] = 0; n_flt[ch] = 0;
            b_one[ch] = 0; b_zero[ch] = 0; b_flt[ch] = 0;
            hold[ch] = 0; rises[ch] = 0; ecnt[ch] = 0;
            acc[ch] = 0; conf[ch] = 0; eflag[ch] = 0;
        end
        m_dac = 12;
    endtask

    // Called right after each posedge: the sample seen is the input driven two edges earlier
    task automatic model_edge();
        logic [3:0] s_hi, s_lo;
        s_hi = q_hi.pop_front();
        s_lo = q_lo.pop_front();
        q_hi.push_back(comp_hi);
        q_lo.push_back(comp_lo);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (s_hi[ch] && !s_lo[ch]) n_one[ch]++;
            else if (s_lo[ch] && !s_hi[ch]) n_zero[ch]++;
            else if (!s_hi[ch] && !s_lo[ch]) n_flt[ch]++;
            else acc[ch] = 1;
            if (s_hi[ch] != p_hi[ch] || s_lo[ch] != p_lo[ch]) eflag[ch] = 1;
            if (s_hi[ch] && !p_hi[ch]) rises[ch]++;
            if (m_w == WIN - 1) begin
                b_one[ch] = bright_of(n_one[ch]);
                b_zero[ch] = bright_of(n_zero[ch]);
                b_flt[ch] = bright_of(n_flt[ch]);
                n_one[ch] = 0; n_zero[ch] = 0; n_flt[ch] = 0;
                conf[ch] = acc[ch]; acc[ch] = 0;
                hold[ch] = eflag[ch] ? HOLD : ((hold[ch] > 0) ? hold[ch] - 1 : 0);
                eflag[ch] = 0;
                ecnt[ch] = (rises[ch] > 65535) ? 65535 : rises[ch];
                rises[ch] = 0;
            end
        end
        p_hi = s_hi; p_lo = s_lo;
        m_dac = dac_of(int'(mode));
        m_w = (m_w + 1) % WIN;
    endtask

    // One clock: observe outputs against the model, drive new inputs, advance the model
    task automatic cycle();
        @(negedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (led_one[ch] !== ((m_w % PH) < b_one[ch])) mis_pwm++;
            if (led_zero[ch] !== ((m_w % PH) < b_zero[ch])) mis_pwm++;
            if (led_floating[ch] !== ((m_w % PH) < b_flt[ch])) mis_pwm++;
            if (led_pulse[ch] !== (hold[ch] != 0)) mis_pulse++;
            if (conflict[ch] !== conf[ch]) mis_conf++;
`ifdef LP_EDGE_COUNT_EN
            if (edge_count[ch*16 +: 16] !== 16'(ecnt[ch])) mis_ecnt++;
`endif
            c_one[ch] += int'(led_one[ch]);
            c_zero[ch] += int'(led_zero[ch]);
            c_flt[ch] += int'(led_floating[ch]);
            c_pulse[ch] += int'(led_pulse[ch]);
        end
        obs_tick = win_tick;
        if (win_tick !== (m_w == WIN - 1)) mis_tick++;
        if (dac_value !== 4'(m_dac)) mis_dac++;
        comp_hi = drv_hi;
        comp_lo = drv_lo;
        mode = drv_mode;
        @(posedge clk);
        model_edge();
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            c_one[ch] = 0; c_zero[ch] = 0; c_flt[ch] = 0; c_pulse[ch] = 0;
        end
    endtask

    task automatic align();
        while (m_w != 0) cycle();
    endtask

    task automatic test_reset();
        pulse_reset = 1'b0;
        comp_hi = '0; comp_lo = '0; mode = 2'd0;
        drv_hi = '0; drv_lo = '0; drv_mode = 2'd0;
        mis_pwm = 0; mis_pulse = 0; mis_conf = 0; mis_tick = 0; mis_dac = 0; mis_ecnt = 0;
        clear_counts();
        repeat (3) @(negedge clk);
        checks++;
        if ({led_one, led_zero, led_floating, led_pulse, conflict, win_tick} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {led_one, led_zero, led_floating, led_pulse, conflict, win_tick});
        end
        checks++;
        if (dac_value !== 4'd12) begin
            failures++;
            $display("FAIL reset_dac: got %0d, expected 12", dac_value);
        end
        model_reset();
        pulse_reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (dac_value !== 4'd7) begin
            failures++;
            $display("FAIL release_dac_mode0: got %0d, expected 7", dac_value);
        end
    endtask

    task automatic test_mode();
        int tab[4] = '{7, 10, 12, 12};
        for (int k = 0; k < 4; k++) begin
            drv_mode = 2'(k);
            cycle();
            #1;
            checks++;
            if (dac_value !== 4'(tab[k])) begin
                failures++;
                $display("FAIL mode_%0d_dac: got %0d, expected %0d", k, dac_value, tab[k]);
            end
        end
    endtask

    task automatic test_full_one();
        align();
        drv_hi = 4'b0001; drv_lo = 4'b0000;
        repeat (2 * WIN) cycle();
        clear_counts();
        repeat (WIN) cycle();
        checks++;
        if (c_one[0] !== 1020) begin
            failures++; $display("FAIL full_one_led_one: got %0d lit cycles, expected 1020", c_one[0]);
        end
        checks++;
        if (c_zero[0] + c_flt[0] !== 0) begin
            failures++; $display("FAIL full_one_others: got %0d lit cycles, expected 0", c_zero[0] + c_flt[0]);
        end
        checks++;
        if (c_flt[1] !== 1020) begin
            failures++; $display("FAIL idle_ch1_floating: got %0d lit cycles, expected 1020", c_flt[1]);
        end
        checks++;
        if (mis_pwm + mis_pulse + mis_conf + mis_tick + mis_dac + mis_ecnt !== 0) begin
            failures++;
            $display("FAIL model_full_one: pwm=%0d pulse=%0d conf=%0d tick=%0d dac=%0d ecnt=%0d bad cycles, expected 0",
                     mis_pwm, mis_pulse, mis_conf, mis_tick, mis_dac, mis_ecnt);
        end
        mis_pwm = 0; mis_pulse = 0; mis_conf = 0; mis_tick = 0; mis_dac = 0; mis_ecnt = 0;
    endtask

    task automatic test_half_zero_float();
        drv_hi = '0; drv_lo = '0;
        align();
        for (int win = 0; win < 3; win++) begin
            if (win == 2) clear_counts();
            for (int c = 0; c < WIN; c++) begin
                drv_lo = {4{(((m_w + 2) % WIN) < 512)}} & 4'b0010;
                cycle();
            end
        end
        drv_lo = '0;
        checks++;
        if (c_zero[1] !== 512) begin
            failures++; $display("FAIL half_led_zero: got %0d lit cycles, expected 512", c_zero[1]);
        end
        checks++;
        if (c_flt[1] !== 512) begin
            failures++; $display("FAIL half_led_floating: got %0d lit cycles, expected 512", c_flt[1]);
        end
        checks++;
        if (c_one[1] !== 0) begin
            failures++; $display("FAIL half_led_one: got %0d lit cycles, expected 0", c_one[1]);
        end
    endtask

    task automatic test_pulse();
        int exp_lit;
        drv_hi = '0; drv_lo = '0;
        align();
        clear_counts();
        for (int c = 0; c < WIN; c++) begin
            drv_hi = {1'b0, (m_w == 100), 2'b00};
            cycle();
        end
        checks++;
        if (c_pulse[2] !== 0) begin
            failures++; $display("FAIL pulse_before_latch: got %0d lit cycles, expected 0", c_pulse[2]);
        end
        for (int k = 0; k < 4; k++) begin
            clear_counts();
            repeat (WIN) cycle();
            exp_lit = (k < HOLD) ? WIN : 0;
            checks++;
            if (c_pulse[2] !== exp_lit) begin
                failures++;
                $display("FAIL pulse_window_%0d: got %0d lit cycles, expected %0d", k + 1, c_pulse[2], exp_lit);
            end
        end
        checks++;
        if (mis_pwm + mis_pulse + mis_conf + mis_tick + mis_dac + mis_ecnt !== 0) begin
            failures++;
            $display("FAIL model_pulse: pwm=%0d pulse=%0d conf=%0d tick=%0d dac=%0d ecnt=%0d bad cycles, expected 0",
                     mis_pwm, mis_pulse, mis_conf, mis_tick, mis_dac, mis_ecnt);
        end
        mis_pwm = 0; mis_pulse = 0; mis_conf = 0; mis_tick = 0; mis_dac = 0; mis_ecnt = 0;
    endtask

    task automatic test_conflict();
        align();
        for (int c = 0; c < WIN; c++) begin
            drv_hi = {(m_w >= 200 && m_w < 210), 3'b000};
            drv_lo = drv_hi;
            cycle();
        end
        #1;
        checks++;
        if (conflict[3] !== 1'b1) begin
            failures++; $display("FAIL conflict_set: got %0b, expected 1", conflict[3]);
        end
        repeat (WIN) cycle();
        #1;
        checks++;
        if (conflict[3] !== 1'b0) begin
            failures++; $display("FAIL conflict_clear: got %0b, expected 0", conflict[3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4 * WIN; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(31) == 0) begin
                    drv_hi[ch] = 1'($urandom_range(1));
                    drv_lo[ch] = 1'($urandom_range(1));
                end
            end
            if ($urandom_range(255) == 0) drv_mode = 2'($urandom_range(3));
            cycle();
        end
        checks++;
        if (mis_pwm + mis_pulse + mis_conf + mis_tick + mis_dac + mis_ecnt !== 0) begin
            failures++;
            $display("FAIL model_random: pwm=%0d pulse=%0d conf=%0d tick=%0d dac=%0d ecnt=%0d bad cycles, expected 0",
                     mis_pwm, mis_pulse, mis_conf, mis_tick, mis_dac, mis_ecnt);
        end
        mis_pwm = 0; mis_pulse = 0; mis_conf = 0; mis_tick = 0; mis_dac = 0; mis_ecnt = 0;
        drv_hi = '0; drv_lo = '0;
    endtask

`ifdef LP_EDGE_COUNT_EN
    task automatic test_edge_count();
        int w;
        drv_hi = '0; drv_lo = '0;
        align();
        for (int c = 0; c < WIN; c++) begin
            w = (m_w + 2) % WIN;
            drv_hi = {3'b000, (w >= 10 && w < 84 && (w % 2 == 1))};
            cycle();
        end
        #1;
        checks++;
        if (edge_count[15:0] !== 16'd37) begin
            failures++; $display("FAIL edge_count_37: got %0d, expected 37", edge_count[15:0]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int first_latch;
        align();
        drv_hi = 4'b0001; drv_lo = '0;
        repeat (WIN) cycle();
        while (m_w != 600) cycle();
        @(negedge clk);
        pulse_reset = 1'b0;
        #1;
        checks++;
        if ({led_one, led_zero, led_floating, led_pulse, conflict, win_tick} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h, expected 0",
                     {led_one, led_zero, led_floating, led_pulse, conflict, win_tick});
        end
        checks++;
        if (dac_value !== 4'd12) begin
            failures++; $display("FAIL midreset_dac: got %0d, expected 12", dac_value);
        end
        repeat (4) @(negedge clk);
        model_reset();
        drv_hi = '0; drv_lo = '0;
        comp_hi = drv_hi; comp_lo = drv_lo;
        pulse_reset = 1'b1;
        @(posedge clk);
        model_edge();
        first_latch = -1;
        for (int n = 0; n < 1100; n++) begin
            cycle();
            if (obs_tick) begin
                first_latch = n + 1;
                break;
            end
        end
        checks++;
        if (first_latch !== 1023) begin
            failures++; $display("FAIL first_latch_edge: got %0d, expected 1023", first_latch);
        end
        repeat (WIN) cycle();
        checks++;
        if (mis_pwm + mis_pulse + mis_conf + mis_tick + mis_dac + mis_ecnt !== 0) begin
            failures++;
            $display("FAIL model_after_reset: pwm=%0d pulse=%0d conf=%0d tick=%0d dac=%0d ecnt=%0d bad cycles, expected 0",
                     mis_pwm, mis_pulse, mis_conf, mis_tick, mis_dac, mis_ecnt);
        end
    endtask

    initial begin
        test_reset();
        test_mode();
        test_full_one();
        test_half_zero_float();
        test_pulse();
        test_conflict();
        test_random();
`ifdef LP_EDGE_COUNT_EN
        test_edge_count();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
